// File: rtl/alien_laser.sv
// alien_laser: one alien shot travelling toward the player column.
// Launches on request, steps on move_tick, resolves hit/miss, cools down.
module alien_laser #(
  parameter int X_MAX    = 155,
  parameter int STEP     = 2,
  parameter int PLAYER_H = 8,
  parameter int COOLDOWN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire_req,
  input  logic [7:0] fire_x,
  input  logic [6:0] fire_y,
  output logic       fire_ack,
  input  logic       move_tick,
  input  logic [6:0] player_y,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       active,
  output logic       hit,
  output logic       miss
);

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_COOL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          act_q, act_d;
  logic          ack_q, ack_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;

  // 9-bit step so a late launch near 255 cannot wrap past the column.
  logic [8:0] x_next;
  // 8-bit window top so player_y near 127 does not wrap.
  logic [7:0] win_hi;
  logic       in_win;

  assign x_next = {1'b0, x_q} + 9'(STEP);
  assign win_hi = {1'b0, player_y} + 8'(PLAYER_H);
  assign in_win = (player_y <= y_q) && ({1'b0, y_q} < win_hi);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state: launch, step, resolve, count down the cooldown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    ack_d   = 1'b0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire_req) begin
          x_d     = fire_x;
          y_d     = fire_y;
          act_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (move_tick) begin
          if (x_next < 9'(X_MAX)) begin
            x_d = x_next[7:0];
          end else begin
            x_d     = 8'(X_MAX);
            act_d   = 1'b0;
            cnt_d   = CW'(COOLDOWN - 1);
            hit_d   = in_win;
            miss_d  = !in_win;
            state_d = S_COOL;
          end
        end
      end
      S_COOL: begin
        if (move_tick) begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fire_ack = ack_q;
  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign active   = act_q;
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_alien_laser.sv
// tb_alien_laser: directed vectors plus hand sequences for alien_laser.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_alien_laser;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire_req;
  logic [7:0] fire_x;
  logic [6:0] fire_y;
  logic       fire_ack;
  logic       move_tick;
  logic [6:0] player_y;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       active;
  logic       hit;
  logic       miss;

  int n_checks = 0;
  int n_fail   = 0;

  alien_laser dut (
    .clk      (clk),
    .reset    (reset),
    .fire_req (fire_req),
    .fire_x   (fire_x),
    .fire_y   (fire_y),
    .fire_ack (fire_ack),
    .move_tick(move_tick),
    .player_y (player_y),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .active   (active),
    .hit      (hit),
    .miss     (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fx;
    logic [6:0] fy;
    logic [6:0] py;
    int         ticks;
    logic       exp_hit;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clock1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    move_tick = 1'b1;
    clock1();
    move_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clock1();
    clock1();
    reset = 1'b0;
  endtask

  task automatic launch(input logic [7:0] fx, input logic [6:0] fy);
    fire_req = 1'b1;
    fire_x   = fx;
    fire_y   = fy;
    clock1();
    fire_req = 1'b0;
  endtask

  // Ticks until hit or miss; returns the tick count (bounded).
  task automatic fly(output int n);
    n = 0;
    while (!(hit || miss) && n < 300) begin
      do_tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int got;
    string nm;

    vecs[0] = '{8'd10,  7'd40,  7'd36,  73, 1'b1};
    vecs[1] = '{8'd10,  7'd43,  7'd36,  73, 1'b1};
    vecs[2] = '{8'd10,  7'd44,  7'd36,  73, 1'b0};
    vecs[3] = '{8'd10,  7'd35,  7'd36,  73, 1'b0};
    vecs[4] = '{8'd100, 7'd127, 7'd125, 28, 1'b1};
    vecs[5] = '{8'd200, 7'd5,   7'd0,   1,  1'b1};
    vecs[6] = '{8'd154, 7'd50,  7'd0,   1,  1'b0};
    vecs[7] = '{8'd153, 7'd0,   7'd120, 1,  1'b0};
    vecs[8] = '{8'd255, 7'd127, 7'd127, 1,  1'b1};

    reset     = 1'b0;
    fire_req  = 1'b0;
    fire_x    = '0;
    fire_y    = '0;
    move_tick = 1'b0;
    player_y  = 7'd36;

    do_reset();
    check("rst_x", x_pos, 0);
    check("rst_y", y_pos, 0);
    check("rst_active", active, 0);
    check("rst_pulses", {fire_ack, hit, miss}, 0);

    // Launch with a simultaneous move_tick: no movement on launch.
    fire_req  = 1'b1;
    move_tick = 1'b1;
    fire_x    = 8'd10;
    fire_y    = 7'd40;
    clock1();
    fire_req  = 1'b0;
    move_tick = 1'b0;
    check("launch_ack", fire_ack, 1);
    check("launch_active", active, 1);
    check("launch_x", x_pos, 10);
    check("launch_y", y_pos, 40);
    clock1();
    check("ack_one_cycle", fire_ack, 0);
    check("hold_no_tick", x_pos, 10);
    do_tick();
    check("first_step", x_pos, 12);

    // Busy: fire_req during flight is ignored.
    launch(8'd77, 7'd3);
    check("busy_no_ack", fire_ack, 0);
    check("busy_x_kept", x_pos, 12);
    check("busy_y_kept", y_pos, 40);

    // Mid-flight reset at x = 60 aborts silently.
    for (int i = 0; i < 24; i++) do_tick();
    check("pre_rst_x", x_pos, 60);
    reset = 1'b1;
    clock1();
    check("rst_mid_pulses", {hit, miss}, 0);
    clock1();
    reset = 1'b0;
    check("rst_mid_x", x_pos, 0);
    check("rst_mid_y", y_pos, 0);
    check("rst_mid_active", active, 0);
    check("rst_mid_pulses2", {hit, miss}, 0);
    launch(8'd1, 7'd1);
    check("rst_mid_reack", fire_ack, 1);

    // Table-driven resolution vectors.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      player_y = vecs[v].py;
      launch(vecs[v].fx, vecs[v].fy);
      check($sformatf("v%0d_ack", v), fire_ack, 1);
      fly(n);
      check($sformatf("v%0d_ticks", v), n, vecs[v].ticks);
      check($sformatf("v%0d_x", v), x_pos, 155);
      check($sformatf("v%0d_active", v), active, 0);
      check($sformatf("v%0d_hit", v), hit, vecs[v].exp_hit);
      check($sformatf("v%0d_miss", v), miss, !vecs[v].exp_hit);
      clock1();
      check($sformatf("v%0d_pulse_end", v), {hit, miss}, 0);
    end

    // Hit path detail: x = 154 after 72 ticks, hit on the 73rd.
    do_reset();
    player_y = 7'd36;
    launch(8'd10, 7'd40);
    for (int i = 0; i < 72; i++) do_tick();
    check("hp_x72", x_pos, 154);
    check("hp_active72", active, 1);
    check("hp_nopulse72", {hit, miss}, 0);
    player_y = 7'd100;
    clock1();
    player_y = 7'd36;
    do_tick();
    check("hp_hit", hit, 1);
    check("hp_miss", miss, 0);

    // Cooldown: held fire_req acked only after 16 further ticks.
    fire_req = 1'b1;
    fire_x   = 8'd20;
    fire_y   = 7'd9;
    got = 0;
    for (int i = 1; i <= 40 && got == 0; i++) begin
      do_tick();
      if (fire_ack) got = i;
      clock1();
      if (fire_ack && got == 0) got = i;
    end
    fire_req = 1'b0;
    check("cool_ticks", got, 16);
    check("cool_active", active, 1);
    check("cool_x", x_pos, 20);
    check("cool_y", y_pos, 9);

    nm = "done";
    if (nm.len() == 0) $display("unexpected");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
